// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word per frame and sends start, data LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN to add a parity bit; PARITY_ODD then selects odd (1) or even (0) parity.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_rdData,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  tx_enable,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("fifo_uart_tx: DATA_WIDTH must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("fifo_uart_tx: PARITY_ODD must be 0 or 1");
    end

    // IDLE: wait/pop | START: line low | DATA: data bits | PARITY: parity bit | STOP: line high
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state;
    logic [CNT_W-1:0]      baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  par_bit;
`endif

    assign bit_end    = (baud_cnt == CNT_LAST);
    assign fifo_rd_en = (state == IDLE) && tx_enable && !fifo_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fifo_rd_en) begin
                        shreg <= fifo_rdData;
`ifdef UART_TX_PARITY_EN
                        par_bit <= (^fifo_rdData) ^ (PARITY_ODD != 0);
`endif
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= par_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            // next bit is presented from shreg[1] as the register shifts
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        // registered pulse lands in the final stop-bit cycle
                        frame_done <= (baud_cnt == CNT_PRE);
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: FIFO model feeds the DUT, a UART receiver monitor checks frames.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    localparam int DW   = 8;
    localparam int CPB  = 4;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NB        = 11;
    localparam int FRAME_CYC = 44;
`else
    localparam int NB        = 10;
    localparam int FRAME_CYC = 40;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_rdData = '0;
    logic          fifo_empty  = 1'b1;
    logic          fifo_rd_en;
    logic          tx_enable;
    logic          tx;
    logic          busy;
    logic          frame_done;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
        .clock(clk), .reset(rst), .fifo_rdData(fifo_rdData), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .tx_enable(tx_enable), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int pop_cyc[$];
    int fd_cyc[$];
    int start_cyc[$];
    int rd_ptr    = 0;
    int underflow = 0;
    int fd_early  = 0;
    int last_brun = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_fd(input int n);
        int budget = 2000;
        while (fd_cyc.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("frame_wait", (fd_cyc.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_pop(input int n);
        int budget = 2000;
        while (pop_cyc.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("pop_wait", (pop_cyc.size() >= n) ? 1 : 0, 1);
    endtask

    // FIFO model: pop decided from the pre-edge strobe, new head presented shortly after the edge
    initial begin
        logic pop_now;
        forever begin
            @(negedge clk);
            pop_now = fifo_rd_en;
            if (fifo_rd_en && fifo_empty) underflow++;
            @(posedge clk);
            #2;
            if (pop_now && rd_ptr < fq.size()) rd_ptr++;
            fifo_empty  = (rd_ptr >= fq.size());
            fifo_rdData = (rd_ptr < fq.size()) ? fq[rd_ptr] : '0;
        end
    end

    // Monitor: records strobes and receives frames off tx, comparing against the scoreboard
    initial begin
        bit            act  = 1'b0;
        int            ph   = 0;
        int            brun = 0;
        logic [DW-1:0] ex   = '0;
        logic [DW-1:0] rx   = '0;
        forever begin
            @(negedge clk);
            if (fifo_rd_en) pop_cyc.push_back(cyc);
            if (frame_done) fd_cyc.push_back(cyc);
            if (busy) brun++;
            else if (brun != 0) begin
                last_brun = brun;
                brun = 0;
            end
            if (rst) begin
                act = 1'b0;
                exp_q.delete();
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act = 1'b1;
                    ph  = 0;
                    rx  = '0;
                    start_cyc.push_back(cyc);
                    check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                end
            end else begin
                ph++;
            end
            if (act && !rst) begin
                if (ph == CPB/2) check("start_bit", int'(tx), 0);
                if (ph >= CPB && ph < (DW+1)*CPB && (ph % CPB) == CPB/2) rx[(ph/CPB)-1] = tx;
`ifdef UART_TX_PARITY_EN
                if (ph == (DW+1)*CPB + CPB/2) check("parity_bit", int'(tx), int'((^ex) ^ PODD[0]));
`endif
                if (ph == (NB-1)*CPB + CPB/2) check("stop_bit", int'(tx), 1);
                if (ph < NB*CPB-1 && frame_done) fd_early++;
                if (ph == NB*CPB-1) begin
                    check("frame_done_last", int'(frame_done), 1);
                    check("frame_data", int'(rx), int'(ex));
                    act = 1'b0;
                end
            end
        end
    end

    initial begin
        int p0, f0, s0, p1, s1, bad, en_cyc;
        rst = 1'b0;
        tx_enable = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_rd_en", int'(fifo_rd_en), 0);
        rst = 1'b0;
        tx_enable = 1'b1;

        // empty FIFO: nothing moves
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("empty_idle", bad, 0);
        check("empty_no_pop", pop_cyc.size(), 0);

        // single byte 0x55
        @(posedge clk); #1;
        p0 = pop_cyc.size(); f0 = fd_cyc.size(); s0 = start_cyc.size();
        push(8'h55);
        wait_fd(f0 + 1);
        repeat (3) @(posedge clk); #1;
        check("b55_pops", pop_cyc.size() - p0, 1);
        check("b55_start_lat", start_cyc[s0] - pop_cyc[p0], 1);
        check("b55_fd_lat", fd_cyc[f0] - pop_cyc[p0], FRAME_CYC);
        check("b55_busy_len", last_brun, FRAME_CYC);

        // back-to-back 0xA3, 0x0F
        p0 = pop_cyc.size(); f0 = fd_cyc.size(); s0 = start_cyc.size();
        push(8'hA3);
        push(8'h0F);
        wait_fd(f0 + 2);
        repeat (3) @(posedge clk); #1;
        check("b2b_pops", pop_cyc.size() - p0, 2);
        check("b2b_pop_gap", pop_cyc[p0+1] - pop_cyc[p0], FRAME_CYC + 1);
        check("b2b_idle_gap", start_cyc[s0+1] - fd_cyc[f0], 2);

        // tx_enable dropped mid-DATA of 0xC4
        p0 = pop_cyc.size(); f0 = fd_cyc.size();
        push(8'hC4);
        push(8'h11);
        push(8'h22);
        wait_pop(p0 + 1);
        repeat (12) @(posedge clk); #1;
        tx_enable = 1'b0;
        wait_fd(f0 + 1);
        repeat (20) @(posedge clk); #1;
        check("hold_pops", pop_cyc.size() - p0, 1);
        check("hold_busy", int'(busy), 0);
        tx_enable = 1'b1;
        en_cyc = cyc;
        wait_fd(f0 + 3);
        repeat (3) @(posedge clk); #1;
        check("reenable_pop_cyc", pop_cyc[p0+1], en_cyc);
        check("reenable_pops", pop_cyc.size() - p0, 3);

        // reset in the middle of 0xFF
        push(8'hFF);
        p0 = pop_cyc.size();
        wait_pop(p0 + 1);
        repeat (10) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_tx", int'(tx), 1);
        check("midrst_busy", int'(busy), 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        p1 = pop_cyc.size(); s1 = start_cyc.size();
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("postrst_idle", bad, 0);
        check("postrst_pops", pop_cyc.size() - p1, 0);
        check("postrst_starts", start_cyc.size() - s1, 0);

`ifdef UART_TX_PARITY_EN
        // parity frame 0x07
        @(posedge clk); #1;
        p0 = pop_cyc.size(); f0 = fd_cyc.size();
        push(8'h07);
        wait_fd(f0 + 1);
        repeat (3) @(posedge clk); #1;
        check("par_fd_lat", fd_cyc[f0] - pop_cyc[p0], 44);
`endif

        check("no_underflow", underflow, 0);
        check("no_early_frame_done", fd_early, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
